// File: rtl/ps2_host_tx.sv
// ps2_host_tx - host-to-device PS/2 transmitter.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop) to a PS/2 device.
// The device supplies the bit clock. The host owns the bus only during the clock-inhibit
// and request-to-send phases. The lines are open-drain and are driven through pull-low enables.
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, the first NACK or timeout
// re-sends the same byte once, and only a second failure reports tx_error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, ACK, WAITIDLE, DONE, ERROR
    } state_t;

    state_t           state;
    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_s;
    logic             data_s;
    logic             clk_filt;
    logic             clk_filt_d;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             fail;
    logic             retry_ok;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Two-flop synchronisers for both asynchronous lines; the idle bus level is high.
    // NOTE: sequential logic uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Glitch filter: the clock level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    // A frame fails when the device is too slow, or when it leaves data high at the ACK clock.
    assign fail = ((state == SHIFT) || (state == ACK)) &&
                  ((tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) || ((state == ACK) && fall && data_s));

`ifdef PS2_TX_RETRY_EN
    logic retried;

    // Remembers that the current byte has already used its single retry.
    always_ff @(posedge clk) begin
        if (reset) begin
            retried <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            retried <= 1'b0;
        end else if (fail) begin
            retried <= 1'b1;
        end
    end

    assign retry_ok = ~retried;
`else
    assign retry_ok = 1'b0;
`endif

    // Transmit sequencer. Each output is updated together with the state transition that implies it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (fail) begin
                tmo_cnt <= '0;
                if (retry_ok) begin
                    state       <= INHIBIT;
                    inh_cnt     <= '0;
                    ps2_clk_oe  <= 1'b1;
                    ps2_data_oe <= 1'b0;
                end else begin
                    state       <= ERROR;
                    tx_error    <= 1'b1;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid && tx_ready) begin
                            data_q     <= tx_data;
                            parity_q   <= ~^tx_data;
                            tx_ready   <= 1'b0;
                            ps2_clk_oe <= 1'b1;
                            inh_cnt    <= '0;
                            state      <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                            ps2_data_oe <= 1'b1;
                            inh_cnt     <= '0;
                            state       <= START;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    START: begin
                        // Release the clock while keeping data low; the low data line is the start bit.
                        ps2_clk_oe <= 1'b0;
                        frame      <= {1'b1, parity_q, data_q};
                        bit_cnt    <= '0;
                        tmo_cnt    <= '0;
                        state      <= SHIFT;
                    end
                    SHIFT: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (fall) begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= {1'b0, frame[9:1]};
                            if (bit_cnt == 4'd9) begin
                                state <= ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ACK: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (fall) begin
                            state <= WAITIDLE;
                        end
                    end
                    WAITIDLE: begin
                        if (clk_filt && data_s) begin
                            tx_done <= 1'b1;
                            state   <= DONE;
                        end
                    end
                    DONE, ERROR: begin
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx - directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 100;
    localparam int TMO  = 5000;
    localparam int FLT  = 4;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch_n = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~ps2_clk_oe & dev_clk & glitch_n;
    assign ps2_data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    int inh_run = 0, inh_last = 0, inh_runs = 0, shift_cyc = 0, err_cyc = 0;
    logic start_after_inh = 1'b0, clk_oe_prev = 1'b0;

    always @(posedge clk) cyc++;

    // Bus observer: pulse counts, inhibit length, SHIFT entry and error timestamps.
    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_error === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (tx_done === 1'b1 && tx_error === 1'b1) overlap_cnt++;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_run++;
        else if (inh_run > 0) begin
            inh_last = inh_run; inh_runs++; inh_run = 0;
            start_after_inh = (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1);
        end
        if (clk_oe_prev === 1'b1 && ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) shift_cyc = cyc;
        clk_oe_prev = ps2_clk_oe;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running after %0d cycles, limit 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Offer one byte on the valid/ready port; ok=0 if it was never accepted.
    task automatic send(input logic [7:0] b, output logic ok);
        ok = 1'b0;
        tx_valid = 1'b1;
        tx_data = b;
        for (int i = 0; i < 20000; i++) begin
            if (tx_ready === 1'b1) begin ok = 1'b1; break; end
            tick;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        tx_data = ~b;
    endtask

    // PS/2 device receiving one host frame. bits[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_frame(input logic ack, input logic glitch, output logic [10:0] bits, output logic got);
        got = 1'b0;
        bits = '0;
        for (int i = 0; i < 1000; i++) begin
            tick;
            if (ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) begin got = 1'b1; break; end
        end
        if (!got) return;
        repeat (HALF) tick;
        bits[0] = ps2_data_line;
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) tick;
            dev_clk = 1'b1;
            bits[i+1] = ps2_data_line;
            if (glitch && i >= 2 && i <= 6) begin
                repeat (HALF / 2) tick;
                glitch_n = 1'b0;
                repeat (2) tick;
                glitch_n = 1'b1;
                repeat (HALF / 2 - 2) tick;
            end else begin
                repeat (HALF) tick;
            end
        end
        if (ack) dev_data = 1'b0;
        repeat (HALF / 2) tick;
        dev_clk = 1'b0;
        repeat (HALF) tick;
        dev_clk = 1'b1;
        repeat (20) tick;
        dev_data = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input logic ack, input logic glitch,
                        output logic ok, output logic got, output logic [10:0] bits);
        logic ok_l, got_l;
        logic [10:0] bits_l;
        fork
            send(b, ok_l);
            dev_frame(ack, glitch, bits_l, got_l);
        join
        ok = ok_l;
        got = got_l;
        bits = bits_l;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
        n_checks++; if (tx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", tx_error); end
        n_checks++; if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        n_checks++; if (ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
        reset = 1'b0;
        repeat (5) tick;
    endtask

    task automatic test_single;
        logic ok, got;
        logic [10:0] bits;
        int d0, e0, i0;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_runs;
        xfer(8'hED, 1'b1, 1'b0, ok, got, bits);
        repeat (50) tick;
        n_checks++; if (ok !== 1'b1 || got !== 1'b1) begin n_fail++; $display("FAIL single_handshake: accepted %b request %b want 1 1", ok, got); end
        n_checks++; if (inh_runs - i0 !== 1) begin n_fail++; $display("FAIL single_inhibit_runs: got %0d want 1", inh_runs - i0); end
        n_checks++; if (inh_last !== INH) begin n_fail++; $display("FAIL single_inhibit_len: got %0d want %0d", inh_last, INH); end
        n_checks++; if (start_after_inh !== 1'b1) begin n_fail++; $display("FAIL single_start_phase: got %b want 1", start_after_inh); end
        n_checks++; if (bits[0] !== 1'b0) begin n_fail++; $display("FAIL single_start_bit: got %b want 0", bits[0]); end
        n_checks++; if (bits[8:1] !== 8'b1110_1101) begin n_fail++; $display("FAIL single_data: got %b want 11101101", bits[8:1]); end
        n_checks++; if (bits[9] !== 1'b1) begin n_fail++; $display("FAIL single_parity: got %b want 1", bits[9]); end
        n_checks++; if (bits[10] !== 1'b1) begin n_fail++; $display("FAIL single_stop: got %b want 1", bits[10]); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_error_count: got %0d want 0", err_cnt - e0); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after: got %b want 1", tx_ready); end
    endtask

    task automatic test_back_to_back;
        logic ok1, ok2, g1, g2;
        logic [10:0] b1, b2;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        fork
            begin send(8'h07, ok1); send(8'h00, ok2); end
            begin dev_frame(1'b1, 1'b0, b1, g1); dev_frame(1'b1, 1'b0, b2, g2); end
        join
        repeat (50) tick;
        n_checks++; if ({ok1, ok2, g1, g2} !== 4'b1111) begin n_fail++; $display("FAIL b2b_handshake: got %b want 1111", {ok1, ok2, g1, g2}); end
        n_checks++; if (b1[8:1] !== 8'h07) begin n_fail++; $display("FAIL b2b_data0: got %h want 07", b1[8:1]); end
        n_checks++; if (b1[9] !== 1'b0) begin n_fail++; $display("FAIL b2b_parity0: got %b want 0", b1[9]); end
        n_checks++; if (b2[8:1] !== 8'h00) begin n_fail++; $display("FAIL b2b_data1: got %h want 00", b2[8:1]); end
        n_checks++; if (b2[9] !== 1'b1) begin n_fail++; $display("FAIL b2b_parity1: got %b want 1", b2[9]); end
        n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_error_count: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_nack;
        logic ok, g1, g2;
        logic [10:0] b1, b2;
        int d0, e0, i0, mid_err;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_runs; mid_err = 0;
        fork
            send(8'h3C, ok);
            begin
                dev_frame(1'b0, 1'b0, b1, g1);
                mid_err = err_cnt - e0;
                dev_frame(1'b0, 1'b0, b2, g2);
            end
        join
        repeat (50) tick;
        n_checks++; if (ok !== 1'b1 || g1 !== 1'b1) begin n_fail++; $display("FAIL nack_first_frame: accepted %b request %b want 1 1", ok, g1); end
        n_checks++; if (b1[8:1] !== 8'h3C) begin n_fail++; $display("FAIL nack_data: got %h want 3c", b1[8:1]); end
`ifdef PS2_TX_RETRY_EN
        n_checks++; if (mid_err !== 0) begin n_fail++; $display("FAIL nack_first_error: got %0d want 0", mid_err); end
        n_checks++; if (g2 !== 1'b1) begin n_fail++; $display("FAIL nack_retry_frame: got %b want 1", g2); end
        n_checks++; if (b2[8:1] !== 8'h3C) begin n_fail++; $display("FAIL nack_retry_data: got %h want 3c", b2[8:1]); end
        n_checks++; if (inh_runs - i0 !== 2) begin n_fail++; $display("FAIL nack_inhibit_runs: got %0d want 2", inh_runs - i0); end
        n_checks++; if (inh_last !== INH) begin n_fail++; $display("FAIL nack_retry_inhibit_len: got %0d want %0d", inh_last, INH); end
`else
        n_checks++; if (mid_err !== 1) begin n_fail++; $display("FAIL nack_first_error: got %0d want 1", mid_err); end
        n_checks++; if (g2 !== 1'b0) begin n_fail++; $display("FAIL nack_no_retry: got %b want 0", g2); end
        n_checks++; if (inh_runs - i0 !== 1) begin n_fail++; $display("FAIL nack_inhibit_runs: got %0d want 1", inh_runs - i0); end
`endif
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL nack_error_count: got %0d want 1", err_cnt - e0); end
        n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL nack_done_count: got %0d want 0", done_cnt - d0); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL nack_ready_after: got %b want 1", tx_ready); end
    endtask

    task automatic test_timeout;
        logic ok, seen;
        int d0, e0, i0;
        d0 = done_cnt; e0 = err_cnt; i0 = inh_runs; seen = 1'b0;
        send(8'h12, ok);
        for (int i = 0; i < 12000; i++) begin
            tick;
            if (err_cnt != e0) begin seen = 1'b1; break; end
        end
        n_checks++; if (ok !== 1'b1 || seen !== 1'b1) begin n_fail++; $display("FAIL timeout_seen: accepted %b error %b want 1 1", ok, seen); end
        n_checks++; if (err_cyc - shift_cyc !== TMO) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", err_cyc - shift_cyc, TMO); end
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL timeout_release: got clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL timeout_ready_pulse: got %b want 0", tx_ready); end
        tick;
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready_after: got %b want 1", tx_ready); end
`ifdef PS2_TX_RETRY_EN
        n_checks++; if (inh_runs - i0 !== 2) begin n_fail++; $display("FAIL timeout_inhibit_runs: got %0d want 2", inh_runs - i0); end
`else
        n_checks++; if (inh_runs - i0 !== 1) begin n_fail++; $display("FAIL timeout_inhibit_runs: got %0d want 1", inh_runs - i0); end
`endif
        n_checks++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin n_fail++; $display("FAIL timeout_pulses: error %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); end
    endtask

    task automatic test_glitch;
        logic ok, got;
        logic [10:0] bits;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        xfer(8'hFF, 1'b1, 1'b1, ok, got, bits);
        repeat (50) tick;
        n_checks++; if (ok !== 1'b1 || got !== 1'b1) begin n_fail++; $display("FAIL glitch_handshake: accepted %b request %b want 1 1", ok, got); end
        n_checks++; if (bits !== 11'b1_1_11111111_0) begin n_fail++; $display("FAIL glitch_frame: got %b want 11111111110", bits); end
        n_checks++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_pulses: done %0d error %0d want 1 0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame;
        logic ok, got;
        logic [10:0] bits;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt; got = 1'b0;
        send(8'hA5, ok);
        for (int i = 0; i < 1000; i++) begin
            tick;
            if (ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) begin got = 1'b1; break; end
        end
        n_checks++; if (ok !== 1'b1 || got !== 1'b1) begin n_fail++; $display("FAIL midreset_request: accepted %b request %b want 1 1", ok, got); end
        repeat (HALF) tick;
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0; repeat (HALF) tick;
            dev_clk = 1'b1; repeat (HALF) tick;
        end
        dev_clk = 1'b0;
        repeat (HALF / 2) tick;
        n_checks++; if (ps2_data_oe !== 1'b1) begin n_fail++; $display("FAIL midreset_bit4: got data_oe %b want 1", ps2_data_oe); end
        reset = 1'b1;
        tick;
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_fail++; $display("FAIL midreset_release: got clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", tx_ready); end
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (300) tick;
        n_checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midreset_no_pulse: done %0d error %0d want 0 0", done_cnt - d0, err_cnt - e0); end
        xfer(8'hF4, 1'b1, 1'b0, ok, got, bits);
        repeat (50) tick;
        n_checks++; if (ok !== 1'b1 || got !== 1'b1) begin n_fail++; $display("FAIL midreset_resend: accepted %b request %b want 1 1", ok, got); end
        n_checks++; if (bits !== 11'b1_0_11110100_0) begin n_fail++; $display("FAIL midreset_frame: got %b want 10111101000", bits); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midreset_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_exclusive;
        n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL done_error_overlap: got %0d want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_nack;
        test_timeout;
        test_glitch;
        test_reset_mid_frame;
        test_exclusive;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
